// File: rtl/hls_key_pkg.sv
// Shared types and defaults for the HLS locking-key loader.
// Optional integrity checking is enabled by defining HLS_KEY_LOADER_CHECK_EN.
package hls_key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    CHECK       = 2'd2,
    COMMIT_WAIT = 2'd3
  } state_t;

  localparam int KEY_W_DEF  = 3071;
  localparam int WORD_W_DEF = 32;

  function automatic int key_words(input int key_w, input int word_w);
    return (key_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/hls_key_loader_if.sv
// Key-stream handshake: a word moves on a rising edge where key_valid and
// key_ready are both 1; the master holds key_data/key_valid until then.
interface hls_key_loader_if #(
  parameter int WORD_W = hls_key_pkg::WORD_W_DEF
);
  logic [WORD_W-1:0] key_data;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_data, output key_valid, input key_ready);
  modport slave  (input key_data, input key_valid, output key_ready);
endinterface

// File: rtl/hls_key_shadow.sv
// Shadow key register, word counter and (with HLS_KEY_LOADER_CHECK_EN)
// the running XOR of all received words including the checksum word.
module hls_key_shadow
  import hls_key_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [WORD_W-1:0] data,
  output logic              last_word,
  output logic [KEY_W-1:0]  shadow
`ifdef HLS_KEY_LOADER_CHECK_EN
  ,
  output logic              sum_ok
`endif
);

  localparam int KEY_WORDS = key_words(KEY_W, WORD_W);
  localparam int CNT_W     = $clog2(KEY_WORDS + 1);
`ifdef HLS_KEY_LOADER_CHECK_EN
  localparam int LOAD_WORDS = KEY_WORDS + 1;
`else
  localparam int LOAD_WORDS = KEY_WORDS;
`endif

  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] wr_mask;
  logic [KEY_W-1:0] data_rep;

  // Each key bit belongs to one word slot; bits past KEY_W simply have no slot.
  for (genvar b = 0; b < KEY_W; b++) begin : g_bit
    assign wr_mask[b]  = (cnt == CNT_W'(b / WORD_W));
    assign data_rep[b] = data[b % WORD_W];
  end

  assign last_word = (cnt == CNT_W'(LOAD_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (clr) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (wr) begin
      cnt    <= cnt + 1'b1;
      shadow <= (shadow & ~wr_mask) | (data_rep & wr_mask);
    end
  end

`ifdef HLS_KEY_LOADER_CHECK_EN
  logic [WORD_W-1:0] acc;

  // Checksum is the XOR of the key words, so folding it in leaves zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (clr)  acc <= '0;
    else if (wr)   acc <= acc ^ data;
  end

  assign sum_ok = (acc == '0);
`endif

endmodule

// File: rtl/hls_key_loader.sv
// Loads a locking key word by word and commits it to the obfuscated core
// only while the core is idle. HLS_KEY_LOADER_CHECK_EN adds a checksum word.
module hls_key_loader
  import hls_key_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  hls_key_loader_if.slave    key_s,
  input  logic               host_start,
  input  logic               core_idle,
  output logic               core_start,
  output logic [KEY_W-1:0]   locking_key,
  output logic               key_loaded,
  output logic               key_err,
  output state_t             state_dbg
);

  state_t           state_q, state_d;
  logic             shadow_clr, shadow_wr, commit, last_word;
  logic [KEY_W-1:0] shadow;
`ifdef HLS_KEY_LOADER_CHECK_EN
  logic             sum_ok, err_set;
`endif

  hls_key_shadow #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_shadow (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .clr       (shadow_clr),
    .wr        (shadow_wr),
    .data      (key_s.key_data),
    .last_word (last_word),
    .shadow    (shadow)
`ifdef HLS_KEY_LOADER_CHECK_EN
    ,
    .sum_ok    (sum_ok)
`endif
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    shadow_clr      = 1'b0;
    shadow_wr       = 1'b0;
    commit          = 1'b0;
    key_s.key_ready = 1'b0;
`ifdef HLS_KEY_LOADER_CHECK_EN
    err_set         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (key_s.key_valid) begin
          state_d    = LOAD;
          shadow_clr = 1'b1;
        end
      end
      LOAD: begin
        key_s.key_ready = 1'b1;
        if (key_s.key_valid) begin
          shadow_wr = 1'b1;
          if (last_word) state_d = CHECK;
        end
      end
      CHECK: begin
`ifdef HLS_KEY_LOADER_CHECK_EN
        if (sum_ok) begin
          state_d = COMMIT_WAIT;
        end else begin
          state_d    = IDLE;
          shadow_clr = 1'b1;
          err_set    = 1'b1;
        end
`else
        state_d = COMMIT_WAIT;
`endif
      end
      COMMIT_WAIT: begin
        // The live key may only change while the core reports idle.
        if (core_idle) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      locking_key <= '0;
      key_loaded  <= 1'b0;
    end else if (commit) begin
      locking_key <= shadow;
      key_loaded  <= 1'b1;
    end
  end

`ifdef HLS_KEY_LOADER_CHECK_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)       key_err <= 1'b0;
    else if (err_set)    key_err <= 1'b1;
    else if (shadow_clr) key_err <= 1'b0;
  end
`else
  assign key_err = 1'b0;
`endif

  // Blocked during COMMIT_WAIT so a start never races the key swap.
  assign core_start = host_start & key_loaded & (state_q != COMMIT_WAIT);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hls_key_loader.sv
// Directed bench for hls_key_loader with a transaction-level key model
// checked every cycle, plus hand-computed spot checks.
module tb_hls_key_loader;
  import hls_key_pkg::*;

  localparam int KEY_W     = 3071;
  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 96;
`ifdef HLS_KEY_LOADER_CHECK_EN
  localparam int NEED = KEY_WORDS + 1;
`else
  localparam int NEED = KEY_WORDS;
`endif

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic host_start = 1'b0;
  logic core_idle = 1'b0;
  logic core_start, key_loaded, key_err;
  logic [KEY_W-1:0] locking_key;
  state_t state_dbg;
  int cyc = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  hls_key_loader_if #(.WORD_W(WORD_W)) kif ();

  hls_key_loader #(.KEY_W(KEY_W), .WORD_W(WORD_W)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .key_s       (kif),
    .host_start  (host_start),
    .core_idle   (core_idle),
    .core_start  (core_start),
    .locking_key (locking_key),
    .key_loaded  (key_loaded),
    .key_err     (key_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / reporting ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [WORD_W-1:0] act,
                            input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_key(input string name, input logic [KEY_W-1:0] act,
                           input logic [KEY_W-1:0] exp);
    logic [KEY_WORDS*WORD_W-1:0] pa, pe;
    checks++;
    if (act !== exp) begin
      failures++;
      pa = {1'b0, act};
      pe = {1'b0, exp};
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (pa[i*WORD_W +: WORD_W] !== pe[i*WORD_W +: WORD_W]) begin
          $display("FAIL %s word%0d got=%h exp=%h t=%0t", name, i,
                   pa[i*WORD_W +: WORD_W], pe[i*WORD_W +: WORD_W], $time);
          break;
        end
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the key words received so far and when the committed key changes.
  logic [WORD_W-1:0] rx_q[$];
  bit m_busy = 0, m_checked = 0, m_loaded = 0, m_err = 0;
  logic [KEY_W-1:0] m_key = '0;
  logic [KEY_WORDS*WORD_W-1:0] m_full;
  logic [WORD_W-1:0] m_sum;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rx_q.delete();
      m_busy = 0; m_checked = 0; m_loaded = 0; m_err = 0; m_key = '0;
    end else if (!m_busy) begin
      if (kif.key_valid) begin
        m_busy = 1; m_checked = 0; m_err = 0;
        rx_q.delete();
      end
    end else if (rx_q.size() < NEED) begin
      if (kif.key_valid) rx_q.push_back(kif.key_data);
    end else if (!m_checked) begin
      m_checked = 1;
      m_sum = '0;
      foreach (rx_q[i]) m_sum ^= rx_q[i];
      if (NEED > KEY_WORDS && m_sum != '0) begin
        m_err = 1; m_busy = 0;
      end
    end else if (core_idle) begin
      m_full = '0;
      for (int i = 0; i < KEY_WORDS; i++) m_full[i*WORD_W +: WORD_W] = rx_q[i];
      m_key = m_full[KEY_W-1:0];
      m_loaded = 1; m_busy = 0;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge ap_clk) begin
    check_bit("key_ready", kif.key_ready, m_busy && (rx_q.size() < NEED));
    check_bit("core_start", core_start, host_start && m_loaded && !(m_busy && m_checked));
    check_bit("key_loaded", key_loaded, m_loaded);
    check_bit("key_err", key_err, m_err);
    check_key("locking_key", locking_key, m_key);
  end

  // ---------------- driver tasks ----------------
  logic [WORD_W-1:0] tx_q[$];

  task automatic build_words(input int kind, input bit bad_sum);
    logic [WORD_W-1:0] s;
    tx_q.delete();
    s = '0;
    for (int i = 0; i < KEY_WORDS; i++) begin
      case (kind)
        0:       tx_q.push_back(WORD_W'(i));
        1:       tx_q.push_back(32'hFFFF_FFFF);
        2:       tx_q.push_back((WORD_W'(i) * 32'h0101_0101) ^ 32'hDEAD_BEEF);
        default: tx_q.push_back(32'hA5A5_A5A5);
      endcase
      s ^= tx_q[i];
    end
    if (NEED > KEY_WORDS) tx_q.push_back(bad_sum ? (s ^ 32'h1) : s);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, output bit ok);
    int guard;
    guard = 0;
    kif.key_data  = w;
    kif.key_valid = 1'b1;
    while (kif.key_ready !== 1'b1 && guard < 50) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout key_ready stuck=%0b exp=1", kif.key_ready);
      ok = 0;
    end else begin
      @(posedge ap_clk); #1;
      ok = 1;
    end
  endtask

  task automatic load_words(input int n, input bit toggle, output int dur);
    bit ok;
    int t0;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      send_word(tx_q[i], ok);
      if (!ok) break;
      if (i == 0) t0 = cyc;
      if (toggle && i < n - 1) begin
        kif.key_valid = 1'b0;
        @(posedge ap_clk); #1;
      end
    end
    dur = cyc - t0;
    kif.key_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [KEY_W-1:0] zero_key;
  logic [KEY_W-1:0] ones_key;
  logic [WORD_W-1:0] w95;
  int dur_b2b, dur_tog, dur_tmp;

  initial begin
    zero_key = '0;
    ones_key = '1;
    w95 = 32'h0000_005F;
    kif.key_data  = '0;
    kif.key_valid = 1'b0;

    repeat (2) @(posedge ap_clk);
    #1;
    check_key("rst_locking_key", locking_key, zero_key);
    check_bit("rst_key_loaded", key_loaded, 1'b0);
    check_bit("rst_key_ready", kif.key_ready, 1'b0);
    check_bit("rst_key_err", key_err, 1'b0);
    ap_rst_n = 1'b1;

    // start requests before any key is present are dropped
    @(posedge ap_clk); #1;
    host_start = 1'b1; #1;
    check_bit("start_no_key", core_start, 1'b0);
    @(posedge ap_clk); #1;
    check_bit("start_no_key_2", core_start, 1'b0);
    host_start = 1'b0;

    // ramp key, core idle: commit lands two edges after the last word
    core_idle = 1'b1;
    build_words(0, 0);
    load_words(NEED, 0, dur_b2b);
    check_bit("loaded_at_last_word", key_loaded, 1'b0);
    @(posedge ap_clk); #1;
    check_bit("loaded_after_check", key_loaded, 1'b0);
    @(posedge ap_clk); #1;
    check_bit("loaded_2_cycles", key_loaded, 1'b1);
    check_word("ramp_w0", locking_key[31:0], 32'h0000_0000);
    check_word("ramp_w1", locking_key[63:32], 32'h0000_0001);
    check_bit("ramp_bit3070", locking_key[3070], w95[30]);
    check_word("ramp_top", {1'b0, locking_key[3070:3040]}, 32'h0000_005F);
    check_int("b2b_duration", dur_b2b, NEED - 1);
    host_start = 1'b1; #1;
    check_bit("start_after_commit", core_start, 1'b1);
    @(posedge ap_clk); #1;
    host_start = 1'b0;

    // second load while core busy: old key held until core_idle
    core_idle = 1'b0;
    build_words(1, 0);
    load_words(NEED, 0, dur_tmp);
    host_start = 1'b1;
    repeat (5) @(posedge ap_clk);
    #1;
    check_word("hold_old_w1", locking_key[63:32], 32'h0000_0001);
    check_bit("hold_loaded", key_loaded, 1'b1);
    check_bit("start_in_commit_wait", core_start, 1'b0);
    core_idle = 1'b1; #1;
    check_bit("start_commit_cycle", core_start, 1'b0);
    @(posedge ap_clk); #1;
    check_key("all_ones", locking_key, ones_key);
    check_bit("start_new_key", core_start, 1'b1);
    host_start = 1'b0;

    // valid toggling every cycle: same key, twice the transfer span
    build_words(0, 0);
    load_words(NEED, 1, dur_tog);
    repeat (3) @(posedge ap_clk);
    #1;
    check_word("tog_w0", locking_key[31:0], 32'h0000_0000);
    check_word("tog_w1", locking_key[63:32], 32'h0000_0001);
    check_int("tog_duration", dur_tog, 2 * dur_b2b);

    // asynchronous reset after word 40, then a full reload
    build_words(2, 0);
    host_start = 1'b1;
    load_words(41, 0, dur_tmp);
    kif.key_valid = 1'b1;
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_key("arst_locking_key", locking_key, zero_key);
    check_bit("arst_key_loaded", key_loaded, 1'b0);
    check_bit("arst_key_ready", kif.key_ready, 1'b0);
    check_bit("arst_core_start", core_start, 1'b0);
    check_bit("arst_key_err", key_err, 1'b0);
    kif.key_valid = 1'b0;
    host_start = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    load_words(NEED, 0, dur_tmp);
    repeat (3) @(posedge ap_clk);
    #1;
    check_word("reload_w0", locking_key[31:0], 32'hDEAD_BEEF);
    check_word("reload_w1", locking_key[63:32], 32'hDFAC_BFEE);
    check_bit("reload_loaded", key_loaded, 1'b1);

`ifdef HLS_KEY_LOADER_CHECK_EN
    build_words(3, 0);
    load_words(NEED, 0, dur_tmp);
    repeat (3) @(posedge ap_clk);
    #1;
    check_word("a5_w0", locking_key[31:0], 32'hA5A5_A5A5);
    check_bit("a5_err", key_err, 1'b0);
    build_words(3, 1);
    load_words(NEED, 0, dur_tmp);
    repeat (3) @(posedge ap_clk);
    #1;
    check_bit("badsum_err", key_err, 1'b1);
    check_word("badsum_w0", locking_key[31:0], 32'hA5A5_A5A5);
    check_bit("badsum_loaded", key_loaded, 1'b1);
`endif

    repeat (3) @(posedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_key_loader.md
HLS_KEY_LOADER -- requirements
Module: hls_key_loader

Interface
REQ-001 Parameter KEY_W, default 3071: width of the locking key delivered to the obfuscated HLS core.
REQ-002 Parameter WORD_W, default 32: key-stream word width.
REQ-003 Derived constant KEY_WORDS = ceil(KEY_W/WORD_W): 96 at defaults.
REQ-004 Port ap_clk  in  1  sole clock, rising edge.
REQ-005 Port ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port key_data  in  WORD_W  key stream word.
REQ-007 Port key_valid  in  1  key_data valid.
REQ-008 Port key_ready  out  1  loader accepts key_data this cycle.
REQ-009 Port host_start  in  1  host request to start the core.
REQ-010 Port core_idle  in  1  ap_idle of the downstream obfuscated core.
REQ-011 Port core_start  out  1  ap_start to the downstream core.
REQ-012 Port locking_key  out  KEY_W  committed key to the core.
REQ-013 Port key_loaded  out  1  a committed key is present.
REQ-014 Port key_err  out  1  sticky: last load was rejected.

Function
REQ-015 A word transfers on a rising edge with key_valid=1 and key_ready=1; key_ready is 1 only in LOAD.
REQ-016 FSM states: IDLE, LOAD, CHECK, COMMIT_WAIT; encoding lives in the package.
REQ-017 IDLE->LOAD when key_valid=1; shadow register and word counter are cleared on that edge; key_err is cleared on entry to LOAD.
REQ-018 Word n (0-based) fills shadow bits [n*WORD_W +: WORD_W]; bits at or above KEY_W in the final word are discarded.
REQ-019 The word counter is ceil(log2(KEY_WORDS+1)) bits wide; after KEY_WORDS key words, LOAD->CHECK.
REQ-020 CHECK lasts one cycle, then -> COMMIT_WAIT (checksum handling per REQ-032).
REQ-021 COMMIT_WAIT: on the first edge where core_idle=1, copy the shadow to locking_key in a single cycle, set key_loaded=1 and go to IDLE; locking_key never changes while core_idle=0.
REQ-022 core_start = host_start AND key_loaded AND (state != COMMIT_WAIT); this path is combinational, with zero latency.
REQ-023 host_start while key_loaded=0 is ignored and core_start stays 0; the request is not queued.
REQ-024 A new load while key_loaded=1 keeps the old locking_key and key_loaded=1 until the commit.
REQ-025 key_valid dropping mid-LOAD stalls the counter; there is no timeout.
REQ-026 host_start and commit in the same cycle: core_start=0 that cycle, and the new key applies from the next cycle.

Reset
REQ-027 ap_rst_n=0 immediately forces: state=IDLE, counter=0, shadow=0, locking_key=0, key_loaded=0, key_err=0, key_ready=0, core_start=0.
REQ-028 Reset mid-LOAD or in COMMIT_WAIT discards the partial key; the first edge after deassertion is in IDLE.

Configuration
REQ-029 Macro HLS_KEY_LOADER_CHECK_EN enables key integrity checking.
REQ-030 Defined: LOAD expects KEY_WORDS+1 words, and the extra word is a checksum equal to the XOR of all KEY_WORDS raw words.
REQ-031 Defined, mismatch in CHECK: set key_err=1, discard the shadow, return to IDLE, and leave locking_key and key_loaded unchanged.
REQ-032 Not defined: LOAD takes exactly KEY_WORDS words, CHECK always passes, and key_err is tied to 0.

Structure
REQ-033 Shared package hls_key_pkg holds: FSM state enum, KEY_W/WORD_W defaults, KEY_WORDS computation function.
REQ-034 One sub-module, hls_key_shadow: shadow register, word counter and XOR accumulator; the FSM and commit stay in the top.

Verification
REQ-035 Defaults, no macro: stream words 0x00000000..0x0000005F with core_idle=1 -> key_loaded rises 2 cycles after the 96th word (CHECK, then commit); locking_key[31:0]=0, locking_key[63:32]=1; bit 3070 = bit 30 of word 95.
REQ-036 Loaded key, core_idle=0, second load of all-0xFFFFFFFF words -> locking_key holds the old value until core_idle=1, then all ones in one cycle.
REQ-037 Macro defined, 96 words of 0xA5A5A5A5 plus checksum 0x00000000 -> commit; same words with checksum 0x00000001 -> key_err=1 and locking_key unchanged.
REQ-038 host_start=1 before any commit -> core_start=0; after commit -> core_start=1 in the same cycle.
REQ-039 ap_rst_n pulsed low after word 40 -> all outputs 0 asynchronously; a full reload afterwards commits correctly.
REQ-040 key_valid toggled 1/0 every cycle during LOAD -> identical locking_key to back-to-back streaming, taking twice the cycles.
